// File: rtl/uart_tx_feeder.sv
// Byte FIFO feeding a UART transmitter: accepts bytes over valid/ready and
// launches them one at a time through a tx_enable / busy_tx handshake.
module uart_tx_feeder #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                       sys_clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic                       busy_tx,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_enable,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       sent_pulse
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LAUNCH  = 2'd1;
  localparam logic [1:0] SENDING = 2'd2;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [1:0]        state;
  logic [CNT_W-1:0]  count_next;
  logic              wr_fire;
  logic              pop;

  // Status comes straight from the registered count, so wr_ready never
  // depends combinationally on wr_valid.
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign wr_ready = !full && !rst;

  assign wr_fire = wr_valid && wr_ready && !flush;
  assign pop     = (state == IDLE) && !empty && !busy_tx && !flush;

  always_comb begin
    count_next = count;
    case ({wr_fire, pop})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
    if (flush) count_next = '0;
  end

  // Storage array carries no reset; only pointers and count define contents.
  always_ff @(posedge sys_clk) begin
    if (wr_fire) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      state      <= IDLE;
      tx_enable  <= 1'b0;
      tx_data    <= '0;
      sent_pulse <= 1'b0;
    end else begin
      count      <= count_next;
      sent_pulse <= 1'b0;

      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (wr_fire) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      end

      // Flush only clears storage; an in-flight byte keeps its handshake.
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data   <= mem[rd_ptr];
            tx_enable <= 1'b1;
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (busy_tx) begin
            tx_enable <= 1'b0;
            state     <= SENDING;
          end
        end
        SENDING: begin
          if (!busy_tx) begin
            sent_pulse <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          tx_enable <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
